// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART serializer and future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int unsigned PAR_NONE  = 0;
  localparam int unsigned PAR_ODD   = 1;
  localparam int unsigned PAR_EVEN  = 2;

  // Wide enough for data bit index 0..8 and stop bit index 0..1.
  localparam int unsigned BIT_CNT_W = 4;

  // Frame length in bit times: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned n_bits,
                                             input int unsigned parity,
                                             input int unsigned stop_bits);
    return 1 + n_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (tick_c) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick_c = (count == CNT_MAX);

endmodule

// File: rtl/uart_tx_serializer.sv
// Stream-to-serial UART transmitter: start bit, LSB-first data, optional parity, stop bits.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned N_BITS       = 8,
  parameter int unsigned PARITY       = PAR_NONE,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BITS-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic              tx,
  output logic              busy
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
  end
  if (N_BITS < 5 || N_BITS > 9) begin : g_bad_nbits
    $error("uart_tx_serializer: N_BITS must be 5..9");
  end
  if (PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  uart_state_t          state;
  uart_state_t          state_nxt;
  logic [N_BITS-1:0]    shreg;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 par_bit;
  logic                 tick_c;
  logic                 accept_c;
  logic                 data_last_c;
  logic                 stop_last_c;
  logic                 tx_nxt;
  logic                 ready_nxt;
  logic                 busy_nxt;

  assign accept_c    = s_tvalid & s_tready;
  assign data_last_c = (bit_cnt == BIT_CNT_W'(N_BITS - 1));
  assign stop_last_c = (bit_cnt == BIT_CNT_W'(STOP_BITS - 1));

  // Restarting the timer on acceptance aligns every bit boundary to the accept edge.
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept_c),
    .tick_c(tick_c)
  );

  // State and registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      s_tready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      tx       <= tx_nxt;
      s_tready <= ready_nxt;
      busy     <= busy_nxt;
    end
  end

  // Next-state logic; every non-idle state advances only on a bit boundary.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept_c) state_nxt = ST_START;
      ST_START:  if (tick_c) state_nxt = ST_DATA;
      ST_DATA:   if (tick_c && data_last_c)
                   state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick_c) state_nxt = ST_STOP;
      ST_STOP:   if (tick_c && stop_last_c) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: value the line carries for the bit that begins on this edge.
  always_comb begin
    tx_nxt    = tx;
    ready_nxt = (state_nxt == ST_IDLE);
    busy_nxt  = (state_nxt != ST_IDLE);
    if (accept_c || tick_c) begin
      case (state_nxt)
        ST_START:  tx_nxt = 1'b0;
        // shreg shifts on this same edge, so a data-to-data boundary shows bit 1.
        ST_DATA:   tx_nxt = (state == ST_DATA) ? shreg[1] : shreg[0];
        ST_PARITY: tx_nxt = par_bit;
        default:   tx_nxt = 1'b1;
      endcase
    end
  end

  // Shift register, parity and bit counter (shared by data and stop phases).
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
    end else if (accept_c) begin
      shreg   <= s_tdata;
      bit_cnt <= '0;
      par_bit <= (PARITY == PAR_ODD) ? ~^s_tdata : ^s_tdata;
    end else if (tick_c) begin
      case (state)
        ST_DATA: begin
          shreg   <= shreg >> 1;
          bit_cnt <= data_last_c ? '0 : bit_cnt + BIT_CNT_W'(1);
        end
        ST_STOP: bit_cnt <= stop_last_c ? '0 : bit_cnt + BIT_CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: vector table over three parity modes plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  localparam int CPB     = 4;
  localparam int N_TABLE = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tdata;
  logic       v_n, v_o, v_e;
  logic       rdy_n, rdy_o, rdy_e;
  logic       tx_n, tx_o, tx_e;
  logic       busy_n, busy_o, busy_e;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .N_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
    .clk(clk), .rst(rst), .s_tdata(tdata), .s_tvalid(v_n), .s_tready(rdy_n), .tx(tx_n), .busy(busy_n));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .N_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_o (
    .clk(clk), .rst(rst), .s_tdata(tdata), .s_tvalid(v_o), .s_tready(rdy_o), .tx(tx_o), .busy(busy_o));
  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .N_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
    .clk(clk), .rst(rst), .s_tdata(tdata), .s_tvalid(v_e), .s_tready(rdy_e), .tx(tx_e), .busy(busy_e));

  typedef struct {
    logic [7:0] data;
    int         mode;
    logic       exp_par;
    int         exp_cycles;
  } vec_t;

  vec_t       vecs [N_TABLE+1];
  logic [7:0] exp_q [$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         mon_count = 0;
  int         sel = 0;
  logic       sel_tx, sel_rdy, sel_busy;

  always_comb begin
    case (sel)
      1:       begin sel_tx = tx_o; sel_rdy = rdy_o; sel_busy = busy_o; end
      2:       begin sel_tx = tx_e; sel_rdy = rdy_e; sel_busy = busy_e; end
      default: begin sel_tx = tx_n; sel_rdy = rdy_n; sel_busy = busy_n; end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_valid(input int mode, input logic val);
    case (mode)
      1:       v_o = val;
      2:       v_e = val;
      default: v_n = val;
    endcase
  endtask

  // One-cycle tvalid pulse, then every cycle of the frame is compared with the expected line.
  task automatic send_vec(input int idx);
    vec_t v;
    logic exp_bits [12];
    int   nb, low;
    bit   bad;
    logic bad_val;
    v   = vecs[idx];
    sel = v.mode;
    nb  = v.exp_cycles / CPB;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = v.data[i];
    if (v.mode != 0) exp_bits[9] = v.exp_par;
    exp_bits[nb-1] = 1'b1;
    @(negedge clk);
    check($sformatf("v%0d_ready_before", idx), sel_rdy, 1);
    tdata = v.data;
    set_valid(v.mode, 1'b1);
    if (v.mode == 0) exp_q.push_back(v.data);
    @(negedge clk);
    set_valid(v.mode, 1'b0);
    low = 0; bad = 0; bad_val = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (t > 0) @(negedge clk);
      if (sel_rdy) break;
      low++;
      if (t == 1) check($sformatf("v%0d_busy", idx), sel_busy, 1);
      if (t < nb * CPB) begin
        if (sel_tx !== exp_bits[t/CPB] && !bad) begin bad = 1; bad_val = sel_tx; end
        if (t % CPB == CPB - 1) begin
          check($sformatf("v%0d_tx_bit%0d", idx, t / CPB), bad ? bad_val : sel_tx, exp_bits[t/CPB]);
          bad = 0;
        end
      end
    end
    check($sformatf("v%0d_ready_low_cycles", idx), low, v.exp_cycles);
    check($sformatf("v%0d_tx_idle_after", idx), sel_tx, 1);
    check($sformatf("v%0d_busy_after", idx), sel_busy, 0);
  endtask

  // Serial decoder on the no-parity instance; every recovered byte is matched against the queue.
  initial begin : monitor
    logic [7:0] b;
    bit         ok;
    forever begin
      @(negedge clk);
      if (!rst && tx_n === 1'b0) begin
        ok = 1; b = '0;
        for (int t = 1; t <= 38; t++) begin
          @(negedge clk);
          if (rst) begin ok = 0; break; end
          if (t == 2) check("mon_start_bit", tx_n, 0);
          if (t >= 6 && t <= 34 && (t - 6) % 4 == 0) b[(t-6)/4] = tx_n;
          if (t == 38) check("mon_stop_bit", tx_n, 1);
        end
        if (ok) begin
          mon_count++;
          check("mon_frame_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("mon_byte", b, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int start2, zeros, waited, timeouts, base;
    bit gone;

    vecs[0]  = '{8'h55, 0, 1'b0, 40};
    vecs[1]  = '{8'h07, 1, 1'b0, 44};
    vecs[2]  = '{8'h07, 2, 1'b1, 44};
    vecs[3]  = '{8'h00, 1, 1'b1, 44};
    vecs[4]  = '{8'h00, 2, 1'b0, 44};
    vecs[5]  = '{8'hFF, 1, 1'b1, 44};
    vecs[6]  = '{8'hFF, 2, 1'b0, 44};
    vecs[7]  = '{8'h80, 0, 1'b0, 40};
    vecs[8]  = '{8'h01, 2, 1'b1, 44};
    vecs[9]  = '{8'hC3, 1, 1'b1, 44};
    vecs[10] = '{8'h12, 0, 1'b0, 40};

    rst = 1'b1; tdata = '0; v_n = 1'b0; v_o = 1'b0; v_e = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_tx", tx_n, 1);
    check("reset_ready", rdy_n, 1);
    check("reset_busy", busy_n, 0);
    check("reset_ready_odd", rdy_o, 1);
    check("reset_ready_even", rdy_e, 1);

    for (int i = 0; i < N_TABLE; i++) send_vec(i);
    sel = 0;

    // Back-to-back with tvalid held: second start one cycle after the first stop bit ends.
    @(negedge clk);
    tdata = 8'hA5; v_n = 1'b1; exp_q.push_back(8'hA5);
    @(negedge clk);
    tdata = 8'h3C; exp_q.push_back(8'h3C);
    start2 = -1; gone = 0;
    for (int t = 1; t <= 120; t++) begin
      @(negedge clk);
      if (tx_n === 1'b0 && t >= 36 && start2 < 0) start2 = t;
      if (rdy_n) gone = 1;
      else if (gone && v_n) v_n = 1'b0;
      if (start2 >= 0 && !v_n) break;
    end
    v_n = 1'b0;
    check("b2b_second_start_offset", start2, 41);
    repeat (100) @(negedge clk);
    check("b2b_frames_outstanding", exp_q.size(), 0);
    check("b2b_ready_after", rdy_n, 1);

    // A pulse during the stop bit must be dropped.
    @(negedge clk);
    tdata = 8'h5A; v_n = 1'b1; exp_q.push_back(8'h5A);
    @(negedge clk);
    v_n = 1'b0;
    repeat (37) @(negedge clk);
    check("ignore_ready_in_stop", rdy_n, 0);
    tdata = 8'h99; v_n = 1'b1;
    @(negedge clk);
    v_n = 1'b0;
    zeros = 0;
    for (int t = 39; t < 140; t++) begin
      @(negedge clk);
      if (t >= 41 && tx_n !== 1'b1) zeros++;
    end
    check("ignore_tx_low_cycles", zeros, 0);
    check("ignore_frames_outstanding", exp_q.size(), 0);
    check("ignore_busy_after", busy_n, 0);

    // Reset during data bit 3 of 0xFF, then a clean 0x12.
    base = mon_count;
    @(negedge clk);
    tdata = 8'hFF; v_n = 1'b1;
    @(negedge clk);
    v_n = 1'b0;
    repeat (17) @(negedge clk);
    check("abort_busy_before", busy_n, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_tx", tx_n, 1);
    check("abort_ready", rdy_n, 1);
    check("abort_busy", busy_n, 0);
    repeat (50) @(negedge clk);
    check("abort_no_frame", mon_count - base, 0);
    send_vec(10);
    sel = 0;

    // Handshaking sender streaming a 26-entry ROM.
    base = mon_count; timeouts = 0;
    @(negedge clk);
    for (int i = 0; i < 26; i++) begin
      tdata = 8'(8'h41 + i); v_n = 1'b1; exp_q.push_back(tdata);
      waited = 0;
      while (!rdy_n && waited < 200) begin @(negedge clk); waited++; end
      if (waited >= 200) timeouts++;
      @(negedge clk);
    end
    v_n = 1'b0;
    check("rom_handshake_timeouts", timeouts, 0);
    for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(negedge clk);
    repeat (60) @(negedge clk);
    check("rom_frames_decoded", mon_count - base, 26);
    check("rom_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Consumes the byte stream from the message sender (tdata/tvalid/tready) and drives one asynchronous serial TX line: 8N1 by default, optional parity.
- Last stage before the FPGA pin, in the ROACH2 FRB-detection housekeeping path.
- tready high only while idle, so the sender paces itself on it.
- A transfer occurs on any cycle with s_tvalid & s_tready, including single-cycle tvalid pulses.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per serial bit (100 MHz / 115200); must be >= 2.
- N_BITS, 8: data bits per character, LSB first; range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- s_tdata  in  N_BITS  character to transmit.
- s_tvalid  in  1  s_tdata valid.
- s_tready  out  1  serializer idle, can accept a character.
- tx  out  1  serial line, idles high.
- busy  out  1  high from the acceptance cycle until the last stop bit completes.

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - rst is synchronous, active-high.
  - Reset values: tx = 1, s_tready = 1 (in the cycle after rst deasserts, and held while idle), busy = 0, FSM = IDLE, baud counter = 0, bit counter = 0.
- Acceptance:
  - In IDLE, s_tready = 1.
  - When s_tvalid & s_tready at rising edge k:
    - s_tdata is latched into the shift register.
    - The parity bit is computed from the latched data: odd parity = ~^data, even parity = ^data.
    - FSM -> START; s_tready = 0 and busy = 1 from k+1.
  - s_tvalid without s_tready is ignored. There is no buffering: a held tvalid is taken only once the block returns to IDLE.
- Line timing:
  - tx goes low (start bit) registered at k+1.
  - Every bit lasts exactly CLKS_PER_BIT cycles, timed by a baud counter that counts 0..CLKS_PER_BIT-1.
  - The counter restarts at 0 on acceptance.
  - tx is a registered output; no glitches.
- FSM:
  - IDLE -> START on acceptance.
  - START (1 bit time) -> DATA.
  - DATA: N_BITS bit times, shift register LSB on tx, right shift at each bit boundary. Bit counter 0..N_BITS-1. -> PARITY if PARITY != 0, else STOP.
  - PARITY: 1 bit time -> STOP.
  - STOP: STOP_BITS bit times, tx = 1 -> IDLE.
- Frame length:
  - F = 1 + N_BITS + (PARITY != 0) + STOP_BITS bit times.
  - The last stop bit ends at cycle k + F*CLKS_PER_BIT.
  - On that edge: FSM = IDLE, s_tready = 1, busy = 0.
- Back-to-back:
  - A character accepted on the first idle cycle starts its start bit immediately after the previous stop bit.
  - Minimum inter-character gap = 0 bit times beyond the stop bits.
- Mid-operation:
  - rst at any cycle aborts the frame: tx = 1 and IDLE on the next edge. The partial frame is not resumed.
  - Changes on s_tdata while busy have no effect.
- Bad parameters: an illegal PARITY, STOP_BITS or N_BITS value is a synthesis-time error, raised by a generate-block $error.

Decomposition:
- Package uart_pkg:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP.
  - Parity encoding constants: PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2.
  - Function for frame length F.
- Sub-module uart_baud_tick:
  - Counter with a synchronous clear, a one-cycle tick at count == CLKS_PER_BIT-1, and a wrap to 0.
  - Reused by a future uart_rx.

Test Plan:
- Basic 8N1: CLKS_PER_BIT = 4, PARITY = 0, single tvalid pulse with 0x55.
  - tx = 0, 1,0,1,0,1,0,1,0, 1, each bit held 4 cycles.
  - s_tready low for exactly 40 cycles, then high.
- Parity: PARITY = 1 with byte 0x07 -> parity bit = 0; PARITY = 2 with 0x07 -> parity bit = 1. Frame = 11 bit times = 44 cycles.
- Back-to-back: tvalid held high with 0xA5 then 0x3C.
  - Second start bit begins the cycle after the first stop bit ends.
  - Exactly two frames; no duplicate on the held tvalid.
- Sender integration: drive this block with the message sender and a 26-entry ROM.
  - A serial-decoder monitor recovers all 26 bytes in order.
  - No byte lost and none repeated.
- Reset mid-frame: assert rst during data bit 3 of 0xFF.
  - tx = 1, s_tready = 1 and busy = 0 from the cycle after rst deasserts.
  - Next character 0x12 is transmitted cleanly.
- Ignore while busy: pulse tvalid with 0x99 during the stop bit of the preceding frame.
  - No second frame; tx stays high afterward.
